band_level_meter: RTL and testbench

Per-band level and peak-hold meter that sits directly downstream of the equalizer's weighted band taps (`freq1`..`freq7`, 8-bit signed, top bits of each weighted band). It accumulates the maximum absolute value of each band over a frame of `DECIMATE` audio samples. It then publishes per-band levels plus decaying peak-hold markers for the bar-graph display and hex debug. Bands are processed serially, one per clock, by a small sequencer FSM.

---
 rtl/band_level_meter_if.sv | 26 ++
 rtl/band_level_meter.sv | 157 +++++++++++++++
 tb/tb_band_level_meter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/band_level_meter_if.sv
`default_nettype none
// ============================================================================
// Module   : band_level_meter_if
// Brief    : Sample-side and display-side signals of the band level meter.
// Revision : 1.0
// ============================================================================
interface band_level_meter_if;
    logic        ready;
    logic [55:0] bands_in;
    logic [48:0] levels;
    logic [48:0] peaks;
    logic        frame_valid;
    logic        overrun;
    logic        busy;

    modport master (
        output ready, bands_in,
        input  levels, peaks, frame_valid, overrun, busy
    );

    modport slave (
        input  ready, bands_in,
        output levels, peaks, frame_valid, overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/band_level_meter.sv
`default_nettype none
// ============================================================================
// Module   : band_level_meter
// Brief    : Per-band max-magnitude level and decaying peak-hold meter,
//            processing the seven bands serially one per clock.
// Revision : 1.0
// ============================================================================
module band_level_meter #(
    parameter int DECIMATE    = 256,
    parameter int HOLD_FRAMES = 8,
    parameter int DECAY_STEP  = 4
) (
    input  logic                clock,
    input  logic                reset,
    band_level_meter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] c_last_sample = 16'(DECIMATE - 1);
    localparam logic [7:0]  c_hold        = 8'(HOLD_FRAMES);
    localparam logic [6:0]  c_decay       = 7'(DECAY_STEP);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_idx;
    logic [15:0] r_count;
    logic [7:0]  r_snap   [7];
    logic [6:0]  r_acc    [7];
    logic [6:0]  r_levels [7];
    logic [6:0]  r_peaks  [7];
    logic [7:0]  r_hold   [7];
    logic        r_overrun;

    logic        w_last_band;
    logic        w_frame_end;
    logic [7:0]  w_band;
    logic [7:0]  w_neg;
    logic [6:0]  w_mag;
    logic [6:0]  w_acc_cur;
    logic [6:0]  w_peak_cur;
    logic [7:0]  w_hold_cur;
    logic [6:0]  w_dec;
    logic [48:0] w_levels;
    logic [48:0] w_peaks;

    assign w_last_band = (r_idx == 3'd6);
    assign w_frame_end = (r_count == c_last_sample);
    assign w_band      = r_snap[r_idx];
    assign w_neg       = ~w_band + 8'd1;
    // -128 has no positive 8-bit counterpart, so it pins to full scale
    assign w_mag       = !w_band[7]         ? w_band[6:0] :
                         (w_band == 8'h80)  ? 7'd127      : w_neg[6:0];
    assign w_acc_cur   = r_acc[r_idx];
    assign w_peak_cur  = r_peaks[r_idx];
    assign w_hold_cur  = r_hold[r_idx];
    assign w_dec       = (w_peak_cur > c_decay) ? (w_peak_cur - c_decay) : 7'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.ready) w_next = SCAN;
            SCAN:    if (w_last_band) w_next = w_frame_end ? COMMIT : IDLE;
            COMMIT:  if (w_last_band) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx     <= 3'd0;
            r_count   <= 16'd0;
            r_overrun <= 1'b0;
            for (int n = 0; n < 7; n++) begin
                r_snap[n]   <= 8'd0;
                r_acc[n]    <= 7'd0;
                r_levels[n] <= 7'd0;
                r_peaks[n]  <= 7'd0;
                r_hold[n]   <= 8'd0;
            end
        end else begin
            if (bus.ready && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.ready) begin
                        r_idx <= 3'd0;
                        for (int n = 0; n < 7; n++) begin
                            r_snap[n] <= bus.bands_in[8*n +: 8];
                        end
                    end
                end
                SCAN: begin
                    if (w_mag > w_acc_cur) begin
                        r_acc[r_idx] <= w_mag;
                    end
                    if (w_last_band) begin
                        r_idx   <= 3'd0;
                        r_count <= w_frame_end ? 16'd0 : (r_count + 16'd1);
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                COMMIT: begin
                    r_levels[r_idx] <= w_acc_cur;
                    r_acc[r_idx]    <= 7'd0;
                    if (w_acc_cur >= w_peak_cur) begin
                        r_peaks[r_idx] <= w_acc_cur;
                        r_hold[r_idx]  <= c_hold;
                    end else if (w_hold_cur != 8'd0) begin
                        r_hold[r_idx]  <= w_hold_cur - 8'd1;
                    end else if (w_acc_cur >= w_dec) begin
                        // Level floor catches the decaying marker: treat it as a fresh peak
                        r_peaks[r_idx] <= w_acc_cur;
                        r_hold[r_idx]  <= c_hold;
                    end else begin
                        r_peaks[r_idx] <= w_dec;
                    end
                    r_idx <= w_last_band ? 3'd0 : (r_idx + 3'd1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_levels = '0;
        w_peaks  = '0;
        for (int n = 0; n < 7; n++) begin
            w_levels[7*n +: 7] = r_levels[n];
            w_peaks[7*n +: 7]  = r_peaks[n];
        end
    end

    assign bus.levels      = w_levels;
    assign bus.peaks       = w_peaks;
    assign bus.frame_valid = (r_state == DONE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_band_level_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_band_level_meter
// Brief    : Directed bench for band_level_meter with a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_band_level_meter;

    localparam int DEC  = 4;
    localparam int HOLD = 2;
    localparam int STEP = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    band_level_meter_if bus ();

    band_level_meter #(
        .DECIMATE    (DEC),
        .HOLD_FRAMES (HOLD),
        .DECAY_STEP  (STEP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests  = 0;
    int n_fail   = 0;
    int fv_count = 0;
    int cyc      = 0;

    int m_acc   [7];
    int m_level [7];
    int m_peak  [7];
    int m_hold  [7];
    int m_count;
    int m_busy_left;
    int m_fv_at;
    bit m_overrun;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int mag_of(input logic [7:0] b);
        int v;
        v = int'($signed(b));
        if (v < 0) v = -v;
        if (v > 127) v = 127;
        return v;
    endfunction

    function automatic logic [55:0] bands(input int v1, v2, v3, v4, v5, v6, v7);
        return {8'(v7), 8'(v6), 8'(v5), 8'(v4), 8'(v3), 8'(v2), 8'(v1)};
    endfunction

    function automatic logic [6:0] lvl(input int n);
        return bus.levels[7*(n-1) +: 7];
    endfunction

    function automatic logic [6:0] pk(input int n);
        return bus.peaks[7*(n-1) +: 7];
    endfunction

    task automatic model_clear();
        for (int n = 0; n < 7; n++) begin
            m_acc[n] = 0; m_level[n] = 0; m_peak[n] = 0; m_hold[n] = 0;
        end
        m_count = 0; m_busy_left = 0; m_fv_at = -1; m_overrun = 1'b0;
    endtask

    // Frame-end rule: new level, peak held for HOLD frames, then decays but never below level
    task automatic model_commit();
        int d;
        for (int n = 0; n < 7; n++) begin
            if (m_acc[n] >= m_peak[n]) begin
                m_peak[n] = m_acc[n]; m_hold[n] = HOLD;
            end else if (m_hold[n] > 0) begin
                m_hold[n] = m_hold[n] - 1;
            end else begin
                d = m_peak[n] - STEP;
                if (d < 0) d = 0;
                if (m_acc[n] >= d) begin
                    m_peak[n] = m_acc[n]; m_hold[n] = HOLD;
                end else begin
                    m_peak[n] = d;
                end
            end
            m_level[n] = m_acc[n];
            m_acc[n]   = 0;
        end
    endtask

    always @(negedge clock) begin
        logic [48:0] el;
        logic [48:0] ep;
        bit          eb;
        bit          ef;
        cyc++;
        if (reset) begin
            model_clear();
            check("reset_levels", 64'(bus.levels), 64'd0);
            check("reset_peaks", 64'(bus.peaks), 64'd0);
            check("reset_flags", {61'd0, bus.frame_valid, bus.overrun, bus.busy}, 64'd0);
        end else begin
            eb = (m_busy_left > 0);
            ef = (cyc == m_fv_at);
            for (int n = 0; n < 7; n++) begin
                el[7*n +: 7] = 7'(m_level[n]);
                ep[7*n +: 7] = 7'(m_peak[n]);
            end
            check("busy", 64'(bus.busy), 64'(eb));
            check("frame_valid", 64'(bus.frame_valid), 64'(ef));
            check("overrun", 64'(bus.overrun), 64'(m_overrun));
            if (!eb || ef) begin
                check("levels", 64'(bus.levels), 64'(el));
                check("peaks", 64'(bus.peaks), 64'(ep));
            end
            if (bus.frame_valid) fv_count++;
            if (eb) m_busy_left--;
            if (bus.ready) begin
                if (eb) begin
                    m_overrun = 1'b1;
                end else begin
                    for (int n = 0; n < 7; n++) begin
                        if (mag_of(bus.bands_in[8*n +: 8]) > m_acc[n]) m_acc[n] = mag_of(bus.bands_in[8*n +: 8]);
                    end
                    m_count++;
                    if (m_count == DEC) begin
                        m_count = 0;
                        model_commit();
                        m_busy_left = 15;
                        m_fv_at = cyc + 15;
                    end else begin
                        m_busy_left = 7;
                    end
                end
            end
        end
    end

    task automatic send(input logic [55:0] b);
        @(posedge clock); #1;
        bus.ready = 1'b1; bus.bands_in = b;
        @(posedge clock); #1;
        bus.ready = 1'b0;
        repeat (20) @(posedge clock);
        #2;
    endtask

    task automatic frame(input logic [55:0] b);
        repeat (DEC) send(b);
    endtask

    initial begin
        int exp_p2[4];
        int fv_before;
        exp_p2 = '{100, 100, 96, 92};
        bus.ready = 1'b0;
        bus.bands_in = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);

        // Magnitude and -128 saturation
        send(bands(10, 0, 0, 0, 0, 0, 5));
        send(bands(-50, 0, 0, 0, 0, 0, 5));
        send(bands(20, 0, 0, 0, 0, 0, 5));
        send(bands(-128, 0, 0, 0, 0, 0, 5));
        check("sat_fv_count", 64'(fv_count), 64'd1);
        check("sat_level1", 64'(lvl(1)), 64'd127);
        check("sat_level7", 64'(lvl(7)), 64'd5);
        check("sat_peak1", 64'(pk(1)), 64'd127);
        check("sat_peak7", 64'(pk(7)), 64'd5);

        // Hold then decay on band 2
        frame(bands(0, 100, 0, 0, 0, 0, 0));
        check("hold_level2_f0", 64'(lvl(2)), 64'd100);
        check("hold_peak2_f0", 64'(pk(2)), 64'd100);
        for (int f = 0; f < 4; f++) begin
            frame(bands(0, 0, 0, 0, 0, 0, 0));
            check("hold_level2", 64'(lvl(2)), 64'd0);
            check("hold_peak2", 64'(pk(2)), 64'(exp_p2[f]));
        end

        // Decay floor on band 3
        frame(bands(0, 0, 100, 0, 0, 0, 0));
        frame(bands(0, 0, 0, 0, 0, 0, 0));
        frame(bands(0, 0, 0, 0, 0, 0, 0));
        check("floor_peak3_held", 64'(pk(3)), 64'd100);
        frame(bands(0, 0, 98, 0, 0, 0, 0));
        check("floor_peak3", 64'(pk(3)), 64'd98);
        check("floor_level3", 64'(lvl(3)), 64'd98);
        frame(bands(0, 0, 0, 0, 0, 0, 0));
        check("floor_hold3_reload", 64'(pk(3)), 64'd98);

        // Overrun: second ready at cycle 4 is dropped
        fv_before = fv_count;
        @(posedge clock); #1;
        bus.ready = 1'b1; bus.bands_in = bands(0, 0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        bus.ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        bus.ready = 1'b1; bus.bands_in = bands(0, 0, 0, 50, 0, 0, 0);
        @(posedge clock); #1;
        bus.ready = 1'b0;
        repeat (20) @(posedge clock);
        #2;
        check("ovr_flag", 64'(bus.overrun), 64'd1);
        send(bands(0, 0, 0, 0, 0, 0, 0));
        send(bands(0, 0, 0, 0, 0, 0, 0));
        check("ovr_no_early_frame", 64'(fv_count), 64'(fv_before));
        send(bands(0, 0, 0, 0, 0, 0, 0));
        check("ovr_frame_count", 64'(fv_count), 64'(fv_before + 1));
        check("ovr_level4", 64'(lvl(4)), 64'd0);
        check("ovr_sticky", 64'(bus.overrun), 64'd1);

        // Asynchronous reset mid-SCAN
        fv_before = fv_count;
        @(posedge clock); #1;
        bus.ready = 1'b1; bus.bands_in = bands(60, 60, 60, 60, 60, 60, 60);
        @(posedge clock); #1;
        bus.ready = 1'b0;
        @(posedge clock); #1;
        check("rst_busy_before", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_levels_now", 64'(bus.levels), 64'd0);
        check("rst_peaks_now", 64'(bus.peaks), 64'd0);
        check("rst_busy_now", 64'(bus.busy), 64'd0);
        check("rst_fv_now", 64'(bus.frame_valid), 64'd0);
        check("rst_overrun_now", 64'(bus.overrun), 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (25) @(posedge clock);
        #2;
        check("rst_no_fv", 64'(fv_count), 64'(fv_before));

        // Frame latency: full frame needed after reset, final sample timing
        send(bands(7, 0, 0, 0, 0, 0, 0));
        send(bands(0, 0, 0, 0, 0, 0, 0));
        send(bands(0, 0, 0, 0, 0, 0, 0));
        check("lat_no_early_frame", 64'(fv_count), 64'(fv_before));
        @(posedge clock); #1;
        bus.ready = 1'b1; bus.bands_in = bands(0, 0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        bus.ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            check("lat_busy", 64'(bus.busy), 64'd1);
            check("lat_fv", 64'(bus.frame_valid), 64'(k == 15));
        end
        @(posedge clock); #1;
        bus.ready = 1'b1;
        @(posedge clock); #1;
        bus.ready = 1'b0;
        @(negedge clock);
        check("lat_accept_busy", 64'(bus.busy), 64'd1);
        check("lat_accept_no_ovr", 64'(bus.overrun), 64'd0);
        check("lat_level1", 64'(lvl(1)), 64'd7);
        repeat (20) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
